button_periph: RTL
==================

Name: button_periph

Overview:
- Parametrised memory-mapped peripheral for the module's physical buttons and RGB indicators.
- Features:
  - per-channel synchronise and debounce of NUM_BUTTONS raw inputs;
  - sticky press-event register with write-1-to-clear;
  - masked level interrupt;
  - NUM_LEDS RGB555 colour registers driving rgb_led instances through colour buses and one-cycle set strobes.
- Sits on the CPU data bus beside oleds.

Parameters:
- DATA_WIDTH, 16, bus data width (must be >= NUM_BUTTONS and >= 15)
- ADDR_WIDTH, 16, bus address width
- BASE_ADDR, 16'hC000, first decoded word address
- NUM_BUTTONS, 8, button channels (1..DATA_WIDTH)
- NUM_LEDS, 2, RGB channels (1..8)
- DEBOUNCE_CYCLES, 50000, consecutive stable clocks before a debounced level changes (>= 1)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  bus select; when low, no access takes effect
- we  input  1  write strobe
- re  input  1  read strobe
- write_addr  input  ADDR_WIDTH  write word address
- read_addr  input  ADDR_WIDTH  read word address
- data  input  DATA_WIDTH  write data
- q  output  DATA_WIDTH  registered read data
- buttons_raw  input  NUM_BUTTONS  asynchronous raw buttons, active-high = pressed
- irq  output  1  level interrupt
- led_rgb  output  15*NUM_LEDS  channel k colour at [15k+14:15k] = {r5,g5,b5}
- led_set  output  NUM_LEDS  one-cycle load strobe per channel

Behaviour:
- Reset (async, rst=1): all of the following are 0 immediately.
  - Outputs: q, irq, led_rgb, led_set.
  - State: debounced levels, debounce counters, synchronisers, EVENTS, IRQ_MASK.
- Register map (word offset from BASE_ADDR; width rules):
  - 0 STATUS: RO, debounced levels.
  - 1 EVENTS: R / W1C.
  - 2 IRQ_MASK: RW.
  - 3 ID: RO, {NUM_LEDS[3:0], NUM_BUTTONS[4:0]} zero-extended.
  - 4..4+NUM_LEDS-1 LED_k: RW, bits[14:0].
  - Writes to RO or unmapped offsets are ignored.
  - Reads of unmapped offsets, and of bits >= NUM_BUTTONS in button registers, return 0.
- Bus timing:
  - An access occurs only when en=1 at the clk edge.
  - Read: q updates at the edge where en&re=1, holding the addressed value sampled before any same-edge write. Latency is 1 cycle.
  - q is 0 after any edge with en&re=0.
- Debounce, per channel:
  - Two-flop synchroniser, then counter.
  - While synced != debounced, the counter increments. When it reaches DEBOUNCE_CYCLES-1 and synced still differs, debounced takes synced and the counter clears.
  - Any cycle with synced == debounced clears the counter.
  - Counter width is clog2(DEBOUNCE_CYCLES+1); no wrap is possible.
  - Latency from a stable raw change to debounced change: 2 + DEBOUNCE_CYCLES clocks.
- EVENTS:
  - Bit i sets on a debounced 0->1 transition of channel i. Release edges are not recorded.
  - A write to EVENTS with en&we clears each bit where data=1.
  - Simultaneous set and clear on the same bit: set wins, so no event is lost.
- irq is registered: irq = |(EVENTS & IRQ_MASK), one cycle after the source change.
- LED write:
  - A write to LED_k loads led_rgb channel k with data[14:0].
  - led_set[k] pulses high for exactly the following cycle, and only for that channel.
  - Back-to-back writes give back-to-back pulses.
- en=0: strobes ignored; led_set all 0; q returns 0 on the next edge.
- Reset mid-debounce or mid-pulse: everything aborts to the reset values. Events are not preserved.

Decomposition:
- Shared package btn_periph_pkg holds:
  - register offset constants (OFS_STATUS=0, OFS_EVENTS=1, OFS_MASK=2, OFS_ID=3, OFS_LED0=4);
  - RGB555 field positions (R 14:10, G 9:5, B 4:0).
- Sub-module button_debounce (clk, rst, raw, level, rise) contains one channel's synchroniser, counter and rising-edge pulse. It is instantiated NUM_BUTTONS times with a generate loop.
- Top level holds decode, EVENTS, IRQ_MASK, LED registers and the q mux.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset: assert rst mid-cycle -> q, irq, led_set, led_rgb are 0 with no clock edge; read STATUS returns 16'h0000; read ID returns 16'h0048 (NUM_LEDS=2 << 5 | NUM_BUTTONS=8).
- Debounce: raw[3]=1 held 6 clocks -> STATUS bit3 set exactly 6 clocks later. A 1-clock glitch on raw[5] -> STATUS bit5 never sets and EVENTS stays 0.
- Events / interrupt: write MASK=16'h0008, press button 3 -> EVENTS=16'h0008 and irq=1. Write EVENTS=16'h0008 -> EVENTS=0 and irq falls 1 cycle later.
- Set-wins collision: button 0 debounced rise on the same edge as a W1C of bit 0 -> EVENTS bit0 stays 1. A read issued on that edge returns the pre-edge value.
- LED: write LED_1 = 16'h7C00 -> led_rgb[29:15]=15'h7C00, led_set=2'b10 for exactly 1 cycle. Read LED_1 -> q=16'h7C00 one cycle after re.
- Bus gating: we=1 with en=0 to LED_0 -> no change and no strobe. Read of offset 9 -> q=0. Write to STATUS -> ignored.

Source files
------------

// File: rtl/button_periph_pkg.sv
// Shared constants for the button/RGB peripheral: register offsets,
// RGB555 field positions and the ID word helper.
package btn_periph_pkg;

  localparam int OFS_STATUS = 0;
  localparam int OFS_EVENTS = 1;
  localparam int OFS_MASK   = 2;
  localparam int OFS_ID     = 3;
  localparam int OFS_LED0   = 4;

  localparam int RGB_R_HI = 14;
  localparam int RGB_R_LO = 10;
  localparam int RGB_G_HI = 9;
  localparam int RGB_G_LO = 5;
  localparam int RGB_B_HI = 4;
  localparam int RGB_B_LO = 0;

  // ID register packs {NUM_LEDS[3:0], NUM_BUTTONS[4:0]}
  function automatic int idWord(input int numLeds, input int numButtons);
    return ((numLeds % 16) << 5) | (numButtons % 32);
  endfunction

endpackage

// File: rtl/button_periph_debounce.sv
// One button channel: two-flop synchroniser, stability counter and a
// pulse that is high in the cycle the debounced level is about to rise.
module button_debounce
  import btn_periph_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // debounced level, so any bounce back to agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/button_periph.sv
// Memory-mapped button/RGB peripheral: debounced buttons, sticky W1C press
// events, masked interrupt and RGB555 colour registers with load strobes.
module button_periph
  import btn_periph_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 16'hC000,
  parameter int                    NUM_BUTTONS     = 8,
  parameter int                    NUM_LEDS        = 2,
  parameter int                    DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    we,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH-1:0]   q,
  input  logic [NUM_BUTTONS-1:0]  buttons_raw,
  output logic                    irq,
  output logic [15*NUM_LEDS-1:0]  led_rgb,
  output logic [NUM_LEDS-1:0]     led_set
);

  localparam int ID_VAL = idWord(NUM_LEDS, NUM_BUTTONS);

  logic [NUM_BUTTONS-1:0]      level, rise;
  logic [NUM_BUTTONS-1:0]      events_q, events_d, mask_q, mask_d;
  logic [NUM_LEDS-1:0][14:0]   led_q, led_d;
  logic [NUM_LEDS-1:0]         ledSet_q, ledSet_d;
  logic [DATA_WIDTH-1:0]       q_q, q_d;
  logic                        irq_q, irq_d;
  logic [ADDR_WIDTH-1:0]       wrOfs, rdOfs;
  logic                        wrEn, rdEn;
  logic                        unused_data;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_deb
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (buttons_raw[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // Addresses below the base are rejected so the offset never wraps.
  assign wrOfs = write_addr - BASE_ADDR;
  assign rdOfs = read_addr - BASE_ADDR;
  assign wrEn  = en & we & (write_addr >= BASE_ADDR);
  assign rdEn  = en & re & (read_addr >= BASE_ADDR);

  always_comb begin
    events_d = events_q;
    mask_d   = mask_q;
    led_d    = led_q;
    ledSet_d = '0;
    if (wrEn) begin
      if (wrOfs == ADDR_WIDTH'(OFS_EVENTS)) events_d = events_q & ~data[NUM_BUTTONS-1:0];
      if (wrOfs == ADDR_WIDTH'(OFS_MASK))   mask_d   = data[NUM_BUTTONS-1:0];
      for (int k = 0; k < NUM_LEDS; k++) begin
        if (wrOfs == ADDR_WIDTH'(OFS_LED0 + k)) begin
          led_d[k]    = data[RGB_R_HI:RGB_B_LO];
          ledSet_d[k] = 1'b1;
        end
      end
    end
    // A new press is OR-ed in after the clear so it cannot be lost.
    events_d = events_d | rise;
    irq_d    = |(events_q & mask_q);
  end

  always_comb begin
    q_d = '0;
    if (rdEn) begin
      if (rdOfs == ADDR_WIDTH'(OFS_STATUS)) q_d[NUM_BUTTONS-1:0] = level;
      if (rdOfs == ADDR_WIDTH'(OFS_EVENTS)) q_d[NUM_BUTTONS-1:0] = events_q;
      if (rdOfs == ADDR_WIDTH'(OFS_MASK))   q_d[NUM_BUTTONS-1:0] = mask_q;
      if (rdOfs == ADDR_WIDTH'(OFS_ID))     q_d = DATA_WIDTH'(ID_VAL);
      for (int k = 0; k < NUM_LEDS; k++) begin
        if (rdOfs == ADDR_WIDTH'(OFS_LED0 + k)) q_d[14:0] = led_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      events_q <= '0;
      mask_q   <= '0;
      led_q    <= '0;
      ledSet_q <= '0;
      q_q      <= '0;
      irq_q    <= 1'b0;
    end else begin
      events_q <= events_d;
      mask_q   <= mask_d;
      led_q    <= led_d;
      ledSet_q <= ledSet_d;
      q_q      <= q_d;
      irq_q    <= irq_d;
    end
  end

  assign q           = q_q;
  assign irq         = irq_q;
  assign led_rgb     = led_q;
  assign led_set     = ledSet_q;
  assign unused_data = ^data;

endmodule
